// File: rtl/lfsr_hex_display.sv
// lfsr_hex_display: parametrised Fibonacci LFSR with hold/run/single-step
// modes, automatic lock-up recovery and a registered N-digit hex
// seven-segment driver (DIGITS = WIDTH/4).
// Optional feature macro: LFSR_PERIOD_CNT_EN adds a period measurement
// block. Without the macro the period/period_vld ports are tied to 0.
module lfsr_hex_display #(
    parameter int                 WIDTH          = 8,
    parameter logic [WIDTH-1:0]   TAPS           = 'h1D,
    parameter logic [WIDTH-1:0]   RST_SEED       = 'd1,
    parameter int                 DIV_W          = 16,
    parameter bit                 SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         seed,
    input  logic                     load,
    input  logic [1:0]               mode,
    input  logic [DIV_W-1:0]         div,
    input  logic                     step,
    output logic [WIDTH-1:0]         q,
    output logic                     tick,
    output logic [8*(WIDTH/4)-1:0]   seg,
    output logic [WIDTH:0]           period,
    output logic                     period_vld
);

    localparam int DIGITS = WIDTH / 4;

    logic [WIDTH-1:0]      q_q, q_d;
    logic [DIV_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            mode_q;
    logic                  step_prev_q;
    logic                  tick_q, tick_d;
    logic [8*DIGITS-1:0]   seg_q;

    logic                  fb;
    logic                  lockup;
    logic                  adv;
    logic [WIDTH-1:0]      shift_val;
    logic [DIV_W-1:0]      cnt_eff;

    // Hex nibble to segment byte (a..g,dp with a in bit 7), polarity applied.
    function automatic logic [8*DIGITS-1:0] seg_encode(input logic [WIDTH-1:0] v);
        logic [8*DIGITS-1:0] r;
        logic [7:0]          b;
        r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            case (v[4*k +: 4])
                4'h0: b = 8'hFC;
                4'h1: b = 8'h60;
                4'h2: b = 8'hDA;
                4'h3: b = 8'hF2;
                4'h4: b = 8'h66;
                4'h5: b = 8'hB6;
                4'h6: b = 8'hBE;
                4'h7: b = 8'hE0;
                4'h8: b = 8'hFE;
                4'h9: b = 8'hF6;
                4'hA: b = 8'hFA;
                4'hB: b = 8'h3E;
                4'hC: b = 8'h9C;
                4'hD: b = 8'h7A;
                4'hE: b = 8'h9E;
                default: b = 8'h8E;
            endcase
            r[8*k +: 8] = SEG_ACTIVE_LOW ? ~b : b;
        end
        return r;
    endfunction

    // Advance decision, prescaler and next LFSR state; load wins over advance.
    always_comb begin
        fb        = ^(q_q & TAPS);
        lockup    = (q_q == '0);
        shift_val = lockup ? WIDTH'(1) : {fb, q_q[WIDTH-1:1]};
        // A mode change restarts the prescaler from zero this cycle.
        cnt_eff   = (mode != mode_q) ? '0 : cnt_q;
        adv       = 1'b0;
        cnt_d     = '0;
        q_d       = q_q;
        tick_d    = 1'b0;
        case (mode)
            2'b01: begin
                adv   = (cnt_eff == div);
                cnt_d = adv ? '0 : cnt_eff + DIV_W'(1);
            end
            2'b10: adv = step & ~step_prev_q;
            default: ;
        endcase
        if (load) begin
            q_d   = seed;
            cnt_d = '0;
        end else if (adv) begin
            q_d    = shift_val;
            tick_d = 1'b1;
        end
    end

    // State, prescaler, edge-detect and display registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q         <= RST_SEED;
            cnt_q       <= '0;
            mode_q      <= 2'b00;
            step_prev_q <= 1'b0;
            tick_q      <= 1'b0;
            seg_q       <= seg_encode(RST_SEED);
        end else begin
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode;
            step_prev_q <= step;
            tick_q      <= tick_d;
            seg_q       <= seg_encode(q_q);
        end
    end

    assign q    = q_q;
    assign tick = tick_q;
    assign seg  = seg_q;

`ifdef LFSR_PERIOD_CNT_EN
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [WIDTH:0]   pcnt_q, pcnt_d;
    logic [WIDTH:0]   pcnt_inc;
    logic [WIDTH:0]   period_q, period_d;
    logic             pvld_d, pvld_q;

    // Count advances since the reference state; report when it recurs.
    always_comb begin
        pcnt_inc = (pcnt_q == '1) ? pcnt_q : pcnt_q + (WIDTH+1)'(1);
        ref_d    = ref_q;
        pcnt_d   = pcnt_q;
        period_d = period_q;
        pvld_d   = 1'b0;
        if (load) begin
            ref_d  = seed;
            pcnt_d = '0;
        end else if (adv) begin
            if (lockup) begin
                // Recovery from the all-zero state re-anchors the reference at 1.
                ref_d  = WIDTH'(1);
                pcnt_d = '0;
            end else if (shift_val == ref_q) begin
                period_d = pcnt_inc;
                pvld_d   = 1'b1;
                pcnt_d   = '0;
            end else begin
                pcnt_d = pcnt_inc;
            end
        end
    end

    // Period measurement registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q    <= RST_SEED;
            pcnt_q   <= '0;
            period_q <= '0;
            pvld_q   <= 1'b0;
        end else begin
            ref_q    <= ref_d;
            pcnt_q   <= pcnt_d;
            period_q <= period_d;
            pvld_q   <= pvld_d;
        end
    end

    assign period     = period_q;
    assign period_vld = pvld_q;
`else
    assign period     = '0;
    assign period_vld = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_hex_display.sv
// Testbench for lfsr_hex_display (default parameters). Stimulus pushes the
// expected post-edge outputs into a queue; a monitor pops and compares them
// on every falling edge.
module tb_lfsr_hex_display;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  seed = '0;
    logic        load = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] div = '0;
    logic        step = 1'b0;
    logic [7:0]  q;
    logic        tick;
    logic [15:0] seg;
    logic [8:0]  period;
    logic        period_vld;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  q;
        logic        tick;
        logic [15:0] seg;
        logic [8:0]  period;
        logic        vld;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [7:0] m_q = 8'h01;
    int         m_cnt = 0;
    logic [1:0] m_mode_prev = 2'b00;
    logic       m_step_prev = 1'b0;
    logic [7:0] m_ref = 8'h01;
    int         m_pc = 0;
    int         m_period = 0;

    logic [7:0] seg_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                  8'hFE, 8'hF6, 8'hFA, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

    lfsr_hex_display dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed       (seed),
        .load       (load),
        .mode       (mode),
        .div        (div),
        .step       (step),
        .q          (q),
        .tick       (tick),
        .seg        (seg),
        .period     (period),
        .period_vld (period_vld)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] enc(input logic [7:0] v);
        return {~seg_tab[v[7:4]], ~seg_tab[v[3:0]]};
    endfunction

    // Next state from the feedback rule: new MSB is the parity of the tapped bits.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        int p;
        if (v == 8'h00) return 8'h01;
        p = $countones(v & 8'h1D) % 2;
        return (v >> 1) | (p != 0 ? 8'h80 : 8'h00);
    endfunction

    task automatic drive(input logic r, input logic ld, input logic [7:0] sd,
                         input logic [1:0] md, input logic [15:0] dv, input logic st);
        exp_t e;
        logic adv;
        @(negedge clk);
        #1;
        rst_n = r; load = ld; seed = sd; mode = md; div = dv; step = st;
        e.tick = 1'b0;
        e.vld  = 1'b0;
        if (!r) begin
            m_q = 8'h01; m_cnt = 0; m_mode_prev = 2'b00; m_step_prev = 1'b0;
            m_ref = 8'h01; m_pc = 0; m_period = 0;
            e.seg = enc(8'h01);
        end else begin
            e.seg = enc(m_q);
            adv = 1'b0;
            if (md != m_mode_prev) m_cnt = 0;
            if (md == 2'b01) begin
                if (m_cnt == int'(dv)) begin adv = 1'b1; m_cnt = 0; end
                else m_cnt++;
            end else begin
                m_cnt = 0;
                if (md == 2'b10 && st && !m_step_prev) adv = 1'b1;
            end
            m_step_prev = st;
            m_mode_prev = md;
            if (ld) begin
                m_q = sd; m_cnt = 0; m_ref = sd; m_pc = 0;
            end else if (adv) begin
                e.tick = 1'b1;
                if (m_q == 8'h00) begin
                    m_q = 8'h01; m_ref = 8'h01; m_pc = 0;
                end else begin
                    m_q  = lfsr_next(m_q);
                    m_pc = (m_pc >= 511) ? 511 : m_pc + 1;
                    if (m_q == m_ref) begin
                        m_period = m_pc; e.vld = 1'b1; m_pc = 0;
                    end
                end
            end
        end
        e.q      = m_q;
        e.period = 9'(m_period);
`ifndef LFSR_PERIOD_CNT_EN
        e.period = '0;
        e.vld    = 1'b0;
`endif
        sb.push_back(e);
    endtask

    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Monitor: compare DUT outputs with the oldest expectation each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp("q", int'(q), int'(e.q));
                cmp("tick", int'(tick), int'(e.tick));
                cmp("seg", int'(seg), int'(e.seg));
                cmp("period", int'(period), int'(e.period));
                cmp("period_vld", int'(period_vld), int'(e.vld));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rm;
        logic       rs;
        // Reset
        for (int i = 0; i < 3; i++) drive(0, 0, 8'h00, 2'b00, 16'd0, 0);
        // Free run, div = 0
        for (int i = 0; i < 6; i++) drive(1, 0, 8'h00, 2'b01, 16'd0, 0);
        // Prescaled run, mode change mid-count
        for (int i = 0; i < 10; i++) drive(1, 0, 8'h00, 2'b01, 16'd3, 0);
        for (int i = 0; i < 2; i++) drive(1, 0, 8'h00, 2'b00, 16'd3, 0);
        for (int i = 0; i < 9; i++) drive(1, 0, 8'h00, 2'b01, 16'd3, 0);
        // Single step: held level, then three pulses
        for (int i = 0; i < 10; i++) drive(1, 0, 8'h00, 2'b10, 16'd0, 1);
        for (int i = 0; i < 2; i++) drive(1, 0, 8'h00, 2'b10, 16'd0, 0);
        for (int p = 0; p < 3; p++) begin
            drive(1, 0, 8'h00, 2'b10, 16'd0, 1);
            drive(1, 0, 8'h00, 2'b10, 16'd0, 0);
            drive(1, 0, 8'h00, 2'b10, 16'd0, 0);
        end
        // Load coincident with step edge
        drive(1, 1, 8'h5A, 2'b10, 16'd0, 1);
        drive(1, 0, 8'h00, 2'b10, 16'd0, 0);
        // Zero seed then lock-up recovery
        drive(1, 1, 8'h00, 2'b00, 16'd0, 0);
        for (int i = 0; i < 3; i++) drive(1, 0, 8'h00, 2'b01, 16'd0, 0);
        // Full period free run from 01, reset mid-run
        drive(0, 0, 8'h00, 2'b00, 16'd0, 0);
        for (int i = 0; i < 520; i++) drive(1, 0, 8'h00, 2'b01, 16'd0, 0);
        for (int i = 0; i < 2; i++) drive(0, 0, 8'h00, 2'b01, 16'd0, 0);
        for (int i = 0; i < 20; i++) drive(1, 0, 8'h00, 2'b01, 16'd0, 0);
        // Randomised traffic
        rm = 2'b01;
        rs = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) rm = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) rs = ~rs;
            drive(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom),
                  rm, 16'($urandom_range(0, 4)), rs);
        end
        @(negedge clk);
        @(negedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_hex_display.md
Name: lfsr_hex_display

Overview:
Parametrised Fibonacci LFSR with run modes and an N-digit hex seven-segment driver.
- Register width, tap mask and reset seed are parameters; seed is loadable at run time.
- Advances every cycle, every (div+1) cycles, or once per step-input rising edge; lock-up state is recovered automatically.
- Drives WIDTH/4 registered seven-segment digit codes; sits between board switches/buttons and the display pins of the demo top.

Parameters:
WIDTH, 8, LFSR width in bits; multiple of 4, range 4..32; DIGITS = WIDTH/4
TAPS, 8'h1D, feedback mask; fb = XOR of q[i] where TAPS[i]=1
RST_SEED, 1, value of q on reset; must be nonzero
DIV_W, 16, prescaler counter/compare width
SEG_ACTIVE_LOW, 1, 1 = segment outputs inverted (lit = 0)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
seed  in  WIDTH  value loaded on load
load  in  1  synchronous load strobe, highest priority after reset
mode  in  2  00 hold, 01 run, 10 single-step, 11 = hold
div  in  DIV_W  run-mode prescale; step every div+1 cycles
step  in  1  single-step request (level, edge-detected internally)
q  out  WIDTH  current LFSR state
tick  out  1  one-cycle pulse in the cycle q updates by a shift or recovery
seg  out  8*DIGITS  digit k in seg[8k+7:8k], bit order a,b,c,d,e,f,g,dp (bit7 = a)

Behaviour:
- Reset (rst_n low, asynchronous): q = RST_SEED, prescale count = 0, step_d = 0, tick = 0, seg = encoding of RST_SEED.
- Shift: q_next = {fb, q[WIDTH-1:1]}, where fb = ^(q & TAPS) is computed combinationally from the current q. There is no pipelined feedback register; every advance uses the current state.
- Lock-up: if an advance occurs while q == 0, q_next = 1 instead of the shift. tick still pulses.
- Priority each cycle: load > advance.
  - load = 1: q = seed, including seed = 0. Prescale count clears, tick = 0.
- Advance condition:
  - mode 01: prescale count increments each cycle. When count == div, advance and clear count. div = 0 advances every cycle.
  - mode 10: advance when step & ~step_d. step_d is step registered every cycle regardless of mode.
  - mode 00/11: no advance. Count holds at 0.
- Any change of mode clears the prescale count. This is detected via a registered copy of mode.
- tick is registered and is high in the same cycle the new q is visible.
- seg is registered from q, so seg lags q by one cycle. Each nibble is encoded with dp = 0:
  - 0=FC 1=60 2=DA 3=F2 4=66 5=B6 6=BE 7=E0 8=FE 9=F6 A=FA b=3E C=9C d=7A E=9E F=8E
  - Encoding is inverted bitwise when SEG_ACTIVE_LOW = 1.
- Reset asserted mid-run: immediate return to reset values. Operation resumes on the first clock after deassertion, with mode sampled that cycle.
- Default TAPS with WIDTH = 8 is maximal length, period 255.

Optional Feature:
LFSR_PERIOD_CNT_EN
- Defined: adds outputs period [WIDTH+1 bits] and period_vld [1].
  - Block captures q at reset/load as ref and counts advances since then.
  - When an advance produces q == ref, period = count and period_vld pulses for one cycle. The counter restarts; ref is unchanged.
  - The counter saturates at all ones.
  - A zero seed, then lock-up recovery, sets ref = 1 at recovery.
- Not defined: the ports are still present, tied to 0. No counter logic is synthesised.

Test Plan:
- Reset with defaults -> q = 8'h01, seg = {~8'hFC, ~8'h60} = 16'h039F, tick = 0.
- mode = 01, div = 0 from 8'h01 -> q sequence 80, 40, 20, 10, 88 on consecutive cycles, tick high each cycle; one cycle after q = 80, seg = {~FE, ~FC} = 16'h0103.
- mode = 01, div = 3 -> exactly one advance per 4 cycles; change mode to 00 mid-count, then back to 01 -> first advance 4 cycles later.
- mode = 10, step held high 10 cycles -> single advance; three separate pulses -> three advances; load = 1 with seed = 8'h5A, coincident with a step edge -> q = 5A, no advance.
- load seed = 0, then mode 01 -> q = 0 for one cycle, then 01, then 80; tick pulses on both transitions.
- LFSR_PERIOD_CNT_EN defined, seed 8'h01, free-run -> period_vld pulses after 255 advances with period = 255, and again 255 advances later; rst_n pulsed low mid-run -> q = 01, counter = 0.
